// File: rtl/dbuf_seq_pkg.sv
// Shared types and defaults for the non-overlap gate-drive sequencer.
// State encoding is fixed (OFF = 0); ZC is only reachable with CEL_ZCD_EN.
package dbuf_seq_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_DT_LH = 3'd1,
    ST_HS    = 3'd2,
    ST_DT_HL = 3'd3,
    ST_LS    = 3'd4,
    ST_ZC    = 3'd5
  } seq_state_e;

  localparam int DTW_DEF    = 4;
  localparam int MIN_ON_DEF = 2;

  function automatic logic is_dead(seq_state_e s);
    return (s == ST_DT_LH) || (s == ST_DT_HL);
  endfunction

endpackage

// File: rtl/dbuf_dt_counter.sv
// Dead-time down-counter: load takes max(dt,1), done marks the last dead clock.
// Ports: clk, rst_n, load, dec, dt[DTW-1:0] in; done out.
module dbuf_dt_counter
  import dbuf_seq_pkg::*;
#(
  parameter int DTW = DTW_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           dec,
  input  logic [DTW-1:0] dt,
  output logic           done
);

  logic [DTW-1:0] cnt_q;
  logic [DTW-1:0] cnt_d;

  always_comb begin
    cnt_d = '0;
    if (load) begin
      cnt_d = (dt == '0) ? DTW'(1) : dt;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - DTW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign done = (cnt_q == DTW'(1));

endmodule

// File: rtl/dbuf_nonoverlap_seq.sv
// Non-overlap HS/LS drive sequencer: dead time, min on-time, sticky fault.
// Ports: CELCLK, CELRSTN, en, pwm, fault, dt_hl, dt_lh, [zcd if CEL_ZCD_EN];
// outputs hs_on, ls_on, dt_active, fault_flag (all flops, no input paths).
module dbuf_nonoverlap_seq
  import dbuf_seq_pkg::*;
#(
  parameter int DTW    = DTW_DEF,
  parameter int MIN_ON = MIN_ON_DEF
) (
  input  logic           CELCLK,
  input  logic           CELRSTN,
  input  logic           en,
  input  logic           pwm,
  input  logic           fault,
  input  logic [DTW-1:0] dt_hl,
  input  logic [DTW-1:0] dt_lh,
`ifdef CEL_ZCD_EN
  input  logic           zcd,
`endif
  output logic           hs_on,
  output logic           ls_on,
  output logic           dt_active,
  output logic           fault_flag
);

  localparam int OCW = $clog2(MIN_ON + 1);

  seq_state_e     state_q, state_d;
  logic           en_q, pwm_q, fault_q;
  logic           flag_q, flag_d;
  logic [OCW-1:0] on_cnt_q, on_cnt_d;
  logic           hs_q, ls_q, dta_q;
  logic           dt_load, dt_dec, dt_done;
  logic [DTW-1:0] dt_sel;
`ifdef CEL_ZCD_EN
  logic           zcd_q;
`endif

  // Inputs are sampled once, so every decision sees a clean registered value.
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      en_q    <= 1'b0;
      pwm_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      en_q    <= en;
      pwm_q   <= pwm;
      fault_q <= fault;
    end
  end

`ifdef CEL_ZCD_EN
  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) zcd_q <= 1'b0;
    else          zcd_q <= zcd;
  end
`endif

  always_comb begin
    state_d = state_q;
    flag_d  = flag_q;
    if (!en_q && !fault_q) flag_d = 1'b0;
    if (fault_q) begin
      state_d = ST_OFF;
      flag_d  = 1'b1;
    end else if (!en_q) begin
      state_d = ST_OFF;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          if (!flag_q) state_d = pwm_q ? ST_DT_LH : ST_DT_HL;
        end
        ST_DT_LH, ST_DT_HL: begin
          if (dt_done) state_d = pwm_q ? ST_HS : ST_LS;
        end
        ST_HS: begin
          if (!pwm_q && on_cnt_q >= OCW'(MIN_ON)) state_d = ST_DT_HL;
        end
        ST_LS: begin
          if (pwm_q) state_d = ST_DT_LH;
`ifdef CEL_ZCD_EN
          else if (zcd_q) state_d = ST_ZC;
`endif
        end
`ifdef CEL_ZCD_EN
        ST_ZC: begin
          if (pwm_q) state_d = ST_DT_LH;
        end
`endif
        default: state_d = ST_OFF;
      endcase
    end
  end

  // On-time counts HS cycles: 1 on entry, saturating at MIN_ON.
  always_comb begin
    on_cnt_d = '0;
    if (state_d == ST_HS) begin
      if (state_q != ST_HS)              on_cnt_d = OCW'(1);
      else if (on_cnt_q < OCW'(MIN_ON))  on_cnt_d = on_cnt_q + OCW'(1);
      else                               on_cnt_d = on_cnt_q;
    end
  end

  // One counter serves both dead directions; loaded on entry only.
  assign dt_load = is_dead(state_d) && (state_d != state_q);
  assign dt_dec  = is_dead(state_q);
  assign dt_sel  = (state_d == ST_DT_LH) ? dt_lh : dt_hl;

  dbuf_dt_counter #(
    .DTW (DTW)
  ) u_dt (
    .clk   (CELCLK),
    .rst_n (CELRSTN),
    .load  (dt_load),
    .dec   (dt_dec),
    .dt    (dt_sel),
    .done  (dt_done)
  );

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state_q  <= ST_OFF;
      flag_q   <= 1'b0;
      on_cnt_q <= '0;
      hs_q     <= 1'b0;
      ls_q     <= 1'b0;
      dta_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      flag_q   <= flag_d;
      on_cnt_q <= on_cnt_d;
      hs_q     <= (state_d == ST_HS);
      ls_q     <= (state_d == ST_LS);
      dta_q    <= is_dead(state_d);
    end
  end

  assign hs_on      = hs_q;
  assign ls_on      = ls_q;
  assign dt_active  = dta_q;
  assign fault_flag = flag_q;

endmodule

// File: tb/tb_dbuf_nonoverlap_seq.sv
// Self-checking bench for dbuf_nonoverlap_seq (MIN_ON=4, DTW=4).
// Build with CEL_ZCD_EN defined to also exercise zero-cross handling.
module tb_dbuf_nonoverlap_seq;

  localparam int DTW    = 4;
  localparam int MIN_ON = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           pwm = 1'b0;
  logic           fault = 1'b0;
  logic [DTW-1:0] dt_hl = '0;
  logic [DTW-1:0] dt_lh = '0;
`ifdef CEL_ZCD_EN
  logic           zcd = 1'b0;
`endif
  logic           hs_on, ls_on, dt_active, fault_flag;

  dbuf_nonoverlap_seq #(
    .DTW    (DTW),
    .MIN_ON (MIN_ON)
  ) dut (
    .CELCLK     (clk),
    .CELRSTN    (rst_n),
    .en         (en),
    .pwm        (pwm),
    .fault      (fault),
    .dt_hl      (dt_hl),
    .dt_lh      (dt_lh),
`ifdef CEL_ZCD_EN
    .zcd        (zcd),
`endif
    .hs_on      (hs_on),
    .ls_on      (ls_on),
    .dt_active  (dt_active),
    .fault_flag (fault_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DTW-1:0] dhl;
    logic [DTW-1:0] dlh;
    int             hold;
    int             e_lh;
    int             e_on;
    int             e_hl;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  function automatic logic sig(input int sel);
    case (sel)
      0:       return hs_on;
      1:       return ls_on;
      2:       return dt_active;
      default: return fault_flag;
    endcase
  endfunction

  task automatic push(input int v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string name, input int act);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %0d, nothing expected", name, act);
    end else begin
      e = exp_q.pop_front();
      if (act != e) begin
        errors++;
        $display("FAIL %s: got %0d, expected %0d", name, act, e);
      end
    end
  endtask

  // Advance one edge and sample #1 later; overlap is checked every cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    checks++;
    if (hs_on && ls_on) begin
      errors++;
      $display("FAIL overlap: hs_on=%0b ls_on=%0b, expected not both", hs_on, ls_on);
    end
  endtask

  task automatic wait_until(input int sel, input logic val, input int max,
                            output int n, output int dta);
    n   = 0;
    dta = 0;
    while (sig(sel) !== val) begin
      if (n >= max) begin
        n = -1;
        return;
      end
      if (dt_active) dta++;
      tick();
      n++;
    end
  endtask

  vec_t vt[6];
  int   n, d;

  initial begin
    vt[0] = '{4'd3,  4'd2,  0, 2,  4, 3};
    vt[1] = '{4'd0,  4'd1,  0, 1,  4, 1};
    vt[2] = '{4'd1,  4'd0,  5, 1,  7, 1};
    vt[3] = '{4'd7,  4'd4,  2, 4,  4, 7};
    vt[4] = '{4'd15, 4'd15, 3, 15, 5, 15};
    vt[5] = '{4'd2,  4'd3,  6, 3,  8, 2};

    // Reset state
    #2;
    push(0); check("rst_hs", hs_on);
    push(0); check("rst_ls", ls_on);
    push(0); check("rst_dt", dt_active);
    push(0); check("rst_flag", fault_flag);
    repeat (3) tick();
    rst_n = 1'b1;

    // Bring-up: 2 sample clocks then dt_hl dead clocks before LS
    dt_hl = 4'd3;
    dt_lh = 4'd2;
    en    = 1'b1;
    push(5);
    wait_until(1, 1'b1, 30, n, d);
    check("bringup_ls", n);

    // Table-driven LS->HS->LS cycles
    foreach (vt[i]) begin
      dt_hl = vt[i].dhl;
      dt_lh = vt[i].dlh;
      pwm   = 1'b1;
      push(2);
      push(vt[i].e_lh);
      push(vt[i].e_lh);
      push(vt[i].e_on);
      push(vt[i].e_hl);
      wait_until(1, 1'b0, 10, n, d);
      check("ls_off_lat", n);
      wait_until(0, 1'b1, 40, n, d);
      check("lh_dead", n);
      check("lh_dt_active", d);
      repeat (vt[i].hold) tick();
      pwm = 1'b0;
      wait_until(0, 1'b0, 40, n, d);
      check("hs_on_time", (n < 0) ? n : n + vt[i].hold);
      wait_until(1, 1'b1, 40, n, d);
      check("hl_dead", n);
    end

    // dt change mid-interval is ignored
    dt_lh = 4'd5;
    pwm   = 1'b1;
    push(2);
    wait_until(1, 1'b0, 10, n, d);
    check("dtchg_ls_off", n);
    dt_lh = 4'd1;
    push(5);
    wait_until(0, 1'b1, 40, n, d);
    check("dtchg_dead", n);

    // Fault pulse during HS
    fault = 1'b1;
    tick();
    fault = 1'b0;
    push(1); check("fault_hs_hold", hs_on);
    tick();
    push(0); check("fault_hs", hs_on);
    push(0); check("fault_ls", ls_on);
    push(1); check("fault_flag_set", fault_flag);
    repeat (8) tick();
    push(0); check("fault_stay_hs", hs_on);
    push(0); check("fault_stay_dt", dt_active);
    push(1); check("fault_flag_sticky", fault_flag);
    en = 1'b0;
    repeat (3) tick();
    push(0); check("fault_flag_clr", fault_flag);
    en = 1'b1;
    push(3);
    wait_until(0, 1'b1, 20, n, d);
    check("fault_restart", n);
    pwm = 1'b0;
    wait_until(1, 1'b1, 40, n, d);

    // en removal in LS
    en = 1'b0;
    tick();
    push(1); check("en_off_hold", ls_on);
    tick();
    push(0); check("en_off_ls", ls_on);
    en = 1'b1;
    wait_until(1, 1'b1, 40, n, d);

`ifdef CEL_ZCD_EN
    // Zero-cross in LS parks both switches until the next pwm request
    zcd = 1'b1;
    tick();
    zcd = 1'b0;
    tick();
    push(0); check("zcd_ls_off", ls_on);
    repeat (5) tick();
    push(0); check("zcd_held_ls", ls_on);
    push(0); check("zcd_held_dt", dt_active);
    dt_lh = 4'd3;
    pwm   = 1'b1;
    push(5);
    wait_until(0, 1'b1, 40, n, d);
    check("zcd_to_hs", n);
    pwm = 1'b0;
    wait_until(1, 1'b1, 40, n, d);
`endif

    // Reset mid DT_LH
    dt_lh = 4'd8;
    pwm   = 1'b1;
    repeat (4) tick();
    push(1); check("pre_rst_dt", dt_active);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push(0); check("rst1_hs", hs_on);
    push(0); check("rst1_ls", ls_on);
    push(0); check("rst1_dt", dt_active);
    rst_n = 1'b1;
    tick();
    push(0); check("rel_hs", hs_on);
    push(0); check("rel_ls", ls_on);
    push(0); check("rel_dt", dt_active);
    push(0); check("rel_flag", fault_flag);
    push(9);
    wait_until(0, 1'b1, 40, n, d);
    check("rel_restart", n);

    // Reset mid HS
    tick();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    push(0); check("rst2_hs", hs_on);
    push(0); check("rst2_ls", ls_on);
    push(0); check("rst2_flag", fault_flag);
    #5;
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
